// File: rtl/maxnet_controller_if.sv
// Handshake bundle between the MaxNet top level/datapath and its controller.
// The controller uses the slave modport; the environment drives through master.
interface maxnet_controller_if #(
    parameter int N_PLU  = 4,
    parameter int ITER_W = 8
);
    logic              start;
    logic [N_PLU-1:0]  plu_done;
    logic              finish;
    logic              mux_sel;
    logic              we_a_reg;
    logic              we_prim;
    logic              plu_start;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ITER_W-1:0] iter_count;

    modport master (
        output start, plu_done, finish,
        input  mux_sel, we_a_reg, we_prim, plu_start,
        input  busy, done, timeout, iter_count
    );

    modport slave (
        input  start, plu_done, finish,
        output mux_sel, we_a_reg, we_prim, plu_start,
        output busy, done, timeout, iter_count
    );
endinterface

// File: rtl/maxnet_controller.sv
// MaxNet control FSM: load, launch PLUs, gather done flags, commit, check.
// Moore controls decoded from state; iteration limit and PLU-wait watchdog.
module maxnet_controller #(
    parameter int N_PLU    = 4,
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    maxnet_controller_if.slave bus
);
    localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [N_PLU-1:0]  r_done_seen;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [ITER_W-1:0] r_iter;
    logic              r_timeout;

    logic w_all_done;
    logic w_wait_exp;
    logic w_iter_lim;
    logic w_idle_like;

    // Done flags arriving this cycle count alongside the sticky ones
    assign w_all_done  = &(r_done_seen | bus.plu_done);
    assign w_wait_exp  = (r_wait_cnt == WCNT_W'(WAIT_MAX));
    assign w_iter_lim  = (r_iter == ITER_W'(MAX_ITER));
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_LOAD;
            S_LOAD:   w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT: begin
                if (w_all_done)      w_next = S_UPDATE;
                else if (w_wait_exp) w_next = S_DONE;
            end
            S_UPDATE: w_next = S_CHECK;
            S_CHECK: begin
                if (bus.finish || w_iter_lim) w_next = S_DONE;
                else                          w_next = S_START;
            end
            S_DONE:   if (bus.start) w_next = S_LOAD;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_done_seen <= '0;
            r_wait_cnt  <= '0;
            r_iter      <= '0;
            r_timeout   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Clear on the way into LOAD so a restart shows fresh status
                    if (bus.start) begin
                        r_iter    <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_iter    <= '0;
                    r_timeout <= 1'b0;
                end
                S_START: begin
                    r_done_seen <= '0;
                    r_wait_cnt  <= '0;
                end
                S_WAIT: begin
                    r_done_seen <= r_done_seen | bus.plu_done;
                    if (!w_all_done) begin
                        if (w_wait_exp) r_timeout  <= 1'b1;
                        else            r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (r_iter != '1) r_iter <= r_iter + 1'b1;
                end
                S_CHECK: begin
                    if (!bus.finish && w_iter_lim) r_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mux_sel    = (r_state == S_UPDATE);
    assign bus.we_a_reg   = (r_state == S_LOAD) || (r_state == S_UPDATE);
    assign bus.we_prim    = (r_state == S_LOAD);
    assign bus.plu_start  = (r_state == S_START);
    assign bus.busy       = !w_idle_like;
    assign bus.done       = (r_state == S_DONE);
    assign bus.timeout    = r_timeout;
    assign bus.iter_count = r_iter;
endmodule
